// File: rtl/adc_cfg_pkg.sv
// Shared definitions for the ADC SPI configuration scheduler:
// FSM/grant encodings, power-up word table and readback tags.
package adc_cfg_pkg;

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_ARB    = 3'd1,
    ST_LAUNCH = 3'd2,
    ST_WAIT   = 3'd3,
    ST_NEXT   = 3'd4
  } state_e;

  typedef enum logic [1:0] {
    GR_INIT = 2'd0,
    GR_WR   = 2'd1,
    GR_RD   = 2'd2
  } grant_e;

  localparam logic [15:0] RD_TAG_ADC0 = 16'h0adc;
  localparam logic [15:0] RD_TAG_ADC1 = 16'h1adc;

  // Power-up register words {addr8, data8}, issued in order to each ADC
  function automatic logic [15:0] init_word(input logic [7:0] idx);
    case (idx)
      8'd0:    return 16'h0080;
      8'd1:    return 16'h0100;
      8'd2:    return 16'h0200;
      8'd3:    return 16'h0300;
      8'd4:    return 16'h0481;
      default: return 16'h0000;
    endcase
  endfunction

  function automatic logic [15:0] rd_tag(input logic chan);
    return chan ? RD_TAG_ADC1 : RD_TAG_ADC0;
  endfunction

endpackage

// File: rtl/adc_spi_req_slot.sv
// One-deep request holding register. A load while occupied is dropped
// unless the slot is being cleared in the same cycle, in which case the
// new request replaces the retiring one.
module adc_spi_req_slot #(
  parameter int unsigned W = 16
) (
  input  logic         clk_i,
  input  logic         rst_i,
  input  logic         load_i,
  input  logic         clr_i,
  input  logic [W-1:0] data_i,
  output logic         full_o,
  output logic [W-1:0] data_o,
  output logic         drop_o
);

  logic         full_q;
  logic [W-1:0] data_q;

  assign drop_o = load_i && full_q && !clr_i;
  assign full_o = full_q;
  assign data_o = data_q;

  // Slot occupancy and payload, updated on the falling edge
  always_ff @(negedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      full_q <= 1'b0;
      data_q <= '0;
    end else if (load_i && (!full_q || clr_i)) begin
      full_q <= 1'b1;
      data_q <= data_i;
    end else if (clr_i) begin
      full_q <= 1'b0;
    end
  end

endmodule

// File: rtl/adc_spi_sched.sv
// Scheduler feeding a shared SPI engine for two ADCs: power-up init,
// host writes and register readback bursts, with fixed-priority
// non-preemptive arbitration and a per-word completion timeout.
module adc_spi_sched
  import adc_cfg_pkg::*;
#(
  parameter int unsigned INIT_WORDS = 5,
  parameter int unsigned RD_WORDS   = 5,
  parameter int unsigned TMO_CYC    = 200
) (
  input  logic        cfg_spi_clk,
  input  logic        cfg_rst_in,
  input  logic        wr_req,
  input  logic        wr_chan,
  input  logic [15:0] wr_word,
  input  logic        rd_req,
  input  logic        rd_chan,
  input  logic        init_req,
  output logic        eng_start,
  output logic        eng_chan,
  output logic [15:0] eng_word,
  input  logic        eng_done,
  input  logic [7:0]  eng_rdata,
  output logic        rd_valid,
  output logic [31:0] rd_data,
  output logic        wr_full,
  output logic        init_done,
  output logic        busy,
  output logic [2:0]  err_flags
);

  state_e      state_q;
  grant_e      grant_q, arb_grant, sel_grant;
  logic        chan_q, arb_chan;
  logic [7:0]  idx_q, tmo_q, sel_idx, nwords;
  logic [1:0]  init_pend_q, init_pend_d;
  logic        init_done_q;
  logic [2:0]  err_q;
  logic        eng_start_q, eng_chan_q, rd_valid_q;
  logic [15:0] eng_word_q, sel_word;
  logic [31:0] rd_data_q;

  logic        wr_full_w, rd_full_w, wr_drop, rd_drop, rd_hold_chan;
  logic [16:0] wr_hold;
  logic        last_word, tmo_hit, burst_end, any_pend;
  logic        wr_clr, rd_clr, init_clr, in_init, init_kick;

  adc_spi_req_slot #(.W(17)) u_wr_slot (
    .clk_i  (cfg_spi_clk),
    .rst_i  (cfg_rst_in),
    .load_i (wr_req),
    .clr_i  (wr_clr),
    .data_i ({wr_chan, wr_word}),
    .full_o (wr_full_w),
    .data_o (wr_hold),
    .drop_o (wr_drop)
  );

  // The readback slot stays occupied for the whole burst, so its drop
  // flag covers both "already pending" and "burst in progress".
  adc_spi_req_slot #(.W(1)) u_rd_slot (
    .clk_i  (cfg_spi_clk),
    .rst_i  (cfg_rst_in),
    .load_i (rd_req),
    .clr_i  (rd_clr),
    .data_i (rd_chan),
    .full_o (rd_full_w),
    .data_o (rd_hold_chan),
    .drop_o (rd_drop)
  );

  // Arbitration, next frame selection and burst completion decode
  always_comb begin
    arb_grant = GR_RD;
    arb_chan  = rd_hold_chan;
    if (|init_pend_q) begin
      arb_grant = GR_INIT;
      arb_chan  = ~init_pend_q[0];
    end else if (wr_full_w) begin
      arb_grant = GR_WR;
      arb_chan  = wr_hold[16];
    end

    sel_grant = (state_q == ST_ARB) ? arb_grant : grant_q;
    sel_idx   = (state_q == ST_ARB) ? 8'd0 : idx_q + 8'd1;
    case (sel_grant)
      GR_INIT: sel_word = init_word(sel_idx);
      GR_WR:   sel_word = wr_hold[15:0];
      default: sel_word = {1'b1, sel_idx[6:0], 8'h00};
    endcase

    case (grant_q)
      GR_INIT: nwords = 8'(INIT_WORDS);
      GR_WR:   nwords = 8'd1;
      default: nwords = 8'(RD_WORDS);
    endcase

    last_word = (idx_q == nwords - 8'd1);
    tmo_hit   = (state_q == ST_WAIT) && !eng_done && (tmo_q == 8'(TMO_CYC - 1));
    burst_end = ((state_q == ST_NEXT) && last_word) || tmo_hit;
    wr_clr    = burst_end && (grant_q == GR_WR);
    rd_clr    = burst_end && (grant_q == GR_RD);
    init_clr  = burst_end && (grant_q == GR_INIT);
    any_pend  = (|init_pend_q) || wr_full_w || rd_full_w;

    in_init   = (grant_q == GR_INIT) && (state_q inside {ST_LAUNCH, ST_WAIT, ST_NEXT});
    init_kick = init_req && !in_init;

    init_pend_d = init_pend_q;
    if (init_clr)  init_pend_d[chan_q] = 1'b0;
    if (init_kick) init_pend_d = 2'b11;
  end

  // Main sequencer with registered engine and readback outputs.
  // LAUNCH raises eng_start on its exit edge so a new frame starts no
  // sooner than three cycles after the previous eng_done.
  always_ff @(negedge cfg_spi_clk or posedge cfg_rst_in) begin
    if (cfg_rst_in) begin
      state_q     <= ST_IDLE;
      grant_q     <= GR_INIT;
      chan_q      <= 1'b0;
      idx_q       <= '0;
      tmo_q       <= '0;
      init_pend_q <= 2'b11;
      init_done_q <= 1'b0;
      err_q       <= '0;
      eng_start_q <= 1'b0;
      eng_chan_q  <= 1'b0;
      eng_word_q  <= '0;
      rd_valid_q  <= 1'b0;
      rd_data_q   <= '0;
    end else begin
      eng_start_q <= 1'b0;
      rd_valid_q  <= 1'b0;
      err_q       <= err_q | {tmo_hit, rd_drop, wr_drop};
      init_pend_q <= init_pend_d;
      if (init_kick) begin
        init_done_q <= 1'b0;
      end else if (init_clr && (init_pend_d == 2'b00)) begin
        init_done_q <= 1'b1;
      end

      case (state_q)
        ST_IDLE: begin
          if (any_pend) state_q <= ST_ARB;
        end
        ST_ARB: begin
          grant_q    <= arb_grant;
          chan_q     <= arb_chan;
          idx_q      <= '0;
          eng_chan_q <= arb_chan;
          eng_word_q <= sel_word;
          state_q    <= ST_LAUNCH;
        end
        ST_LAUNCH: begin
          eng_start_q <= 1'b1;
          tmo_q       <= '0;
          state_q     <= ST_WAIT;
        end
        ST_WAIT: begin
          if (eng_done) begin
            if (grant_q == GR_RD) begin
              rd_valid_q <= 1'b1;
              rd_data_q  <= {rd_tag(chan_q), idx_q, eng_rdata};
            end
            state_q <= ST_NEXT;
          end else if (tmo_hit) begin
            state_q <= ST_IDLE;
          end else begin
            tmo_q <= tmo_q + 8'd1;
          end
        end
        ST_NEXT: begin
          if (last_word) begin
            state_q <= ST_IDLE;
          end else begin
            idx_q      <= idx_q + 8'd1;
            eng_word_q <= sel_word;
            state_q    <= ST_LAUNCH;
          end
        end
        default: state_q <= ST_IDLE;
      endcase
    end
  end

  assign eng_start = eng_start_q;
  assign eng_chan  = eng_chan_q;
  assign eng_word  = eng_word_q;
  assign rd_valid  = rd_valid_q;
  assign rd_data   = rd_data_q;
  assign wr_full   = wr_full_w;
  assign init_done = init_done_q;
  assign busy      = (state_q != ST_IDLE);
  assign err_flags = err_q;

endmodule

// File: tb/tb_adc_spi_sched.sv
// Directed bench for adc_spi_sched with a behavioural SPI engine that
// answers 10 cycles after each start with rdata = 8'h10 + frame addr.
module tb_adc_spi_sched;

  logic        cfg_spi_clk, cfg_rst_in;
  logic        wr_req, wr_chan, rd_req, rd_chan, init_req;
  logic [15:0] wr_word;
  logic        eng_start, eng_chan, eng_done;
  logic [15:0] eng_word;
  logic [7:0]  eng_rdata;
  logic        rd_valid, wr_full, init_done, busy;
  logic [31:0] rd_data;
  logic [2:0]  err_flags;

  int checks = 0;
  int errors = 0;

  typedef struct {
    logic        chan;
    logic [15:0] word;
    logic [15:0] lo16;
  } vec_t;

  vec_t init_tbl[10];
  vec_t rb_tbl[5];

  logic [16:0] starts[$];
  logic [31:0] rds[$];
  bit          respond = 1'b1;

  adc_spi_sched #(.INIT_WORDS(5), .RD_WORDS(5), .TMO_CYC(200)) dut (
    .cfg_spi_clk (cfg_spi_clk),
    .cfg_rst_in  (cfg_rst_in),
    .wr_req      (wr_req),
    .wr_chan     (wr_chan),
    .wr_word     (wr_word),
    .rd_req      (rd_req),
    .rd_chan     (rd_chan),
    .init_req    (init_req),
    .eng_start   (eng_start),
    .eng_chan    (eng_chan),
    .eng_word    (eng_word),
    .eng_done    (eng_done),
    .eng_rdata   (eng_rdata),
    .rd_valid    (rd_valid),
    .rd_data     (rd_data),
    .wr_full     (wr_full),
    .init_done   (init_done),
    .busy        (busy),
    .err_flags   (err_flags)
  );

  initial cfg_spi_clk = 1'b0;
  always #50 cfg_spi_clk = ~cfg_spi_clk;

  initial begin
    #(100 * 20000);
    $display("FAIL watchdog: simulation exceeded 20000 cycles");
    $fatal(1, "watchdog");
  end

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  // Engine model, start logger and rd_valid monitor, all sampled on posedge
  initial begin
    int cyc = 0;
    int last_done = -100;
    int cnt = 0;
    logic [15:0] cur_word = '0;
    eng_done  = 1'b0;
    eng_rdata = 8'h00;
    forever begin
      @(posedge cfg_spi_clk);
      cyc++;
      eng_done = 1'b0;
      if (rd_valid === 1'b1) rds.push_back(rd_data);
      if (cfg_rst_in === 1'b1) begin
        cnt = 0;
      end else if (eng_start === 1'b1) begin
        starts.push_back({eng_chan, eng_word});
        checks++;
        if (cyc - last_done < 3) begin
          errors++;
          $display("FAIL start_gap: start %0d cycles after eng_done, expected >= 3", cyc - last_done);
        end
        if (respond) begin
          cnt = 10;
          cur_word = eng_word;
        end
      end else if (cnt > 0) begin
        cnt--;
        if (cnt == 0) begin
          eng_done  = 1'b1;
          eng_rdata = 8'h10 + {1'b0, cur_word[14:8]};
          last_done = cyc;
        end
      end
    end
  end

  task automatic pulse(input bit w, input bit r, input bit i,
                       input logic wch, input logic [15:0] wd, input logic rch);
    @(posedge cfg_spi_clk);
    wr_req = w; wr_chan = wch; wr_word = wd;
    rd_req = r; rd_chan = rch; init_req = i;
    @(posedge cfg_spi_clk);
    wr_req = 1'b0; rd_req = 1'b0; init_req = 1'b0;
  endtask

  task automatic wait_quiet(input string nm);
    int idle = 0;
    int n = 0;
    while (idle < 4 && n < 3000) begin
      @(posedge cfg_spi_clk);
      n++;
      if (busy === 1'b0 && wr_full === 1'b0) idle++;
      else idle = 0;
    end
    if (idle < 4) begin
      checks++; errors++;
      $display("FAIL %s_quiet: still busy after %0d cycles", nm, n);
    end
  endtask

  task automatic wait_starts(input string nm, input int want);
    int seen = 0;
    int n = 0;
    while (seen < want && n < 400) begin
      @(posedge cfg_spi_clk);
      n++;
      if (eng_start === 1'b1) seen++;
    end
    if (seen < want) begin
      checks++; errors++;
      $display("FAIL %s_start_wait: saw %0d starts expected %0d", nm, seen, want);
    end
  endtask

  task automatic check_init_seq(input string nm);
    check({nm, "_count"}, 32'(starts.size()), 32'd10);
    for (int unsigned i = 0; i < 10; i++)
      if (i < starts.size())
        check($sformatf("%s_word%0d", nm, i), {15'd0, starts[i]}, {15'd0, init_tbl[i].chan, init_tbl[i].word});
  endtask

  task automatic check_rb(input string nm, input logic ch, input int unsigned base);
    check({nm, "_rdcount"}, 32'(rds.size()), 32'd5);
    for (int unsigned n = 0; n < 5; n++) begin
      if (base + n < starts.size())
        check($sformatf("%s_frame%0d", nm, n), {15'd0, starts[base + n]}, {15'd0, ch, rb_tbl[n].word});
      else
        check($sformatf("%s_frame%0d_missing", nm, n), 32'(starts.size()), 32'(base + n + 1));
      if (n < rds.size())
        check($sformatf("%s_rd%0d", nm, n), rds[n], {(ch ? 16'h1adc : 16'h0adc), rb_tbl[n].lo16});
    end
  endtask

  initial begin
    int n;
    init_tbl[0] = '{1'b0, 16'h0080, 16'h0}; init_tbl[1] = '{1'b0, 16'h0100, 16'h0};
    init_tbl[2] = '{1'b0, 16'h0200, 16'h0}; init_tbl[3] = '{1'b0, 16'h0300, 16'h0};
    init_tbl[4] = '{1'b0, 16'h0481, 16'h0}; init_tbl[5] = '{1'b1, 16'h0080, 16'h0};
    init_tbl[6] = '{1'b1, 16'h0100, 16'h0}; init_tbl[7] = '{1'b1, 16'h0200, 16'h0};
    init_tbl[8] = '{1'b1, 16'h0300, 16'h0}; init_tbl[9] = '{1'b1, 16'h0481, 16'h0};
    rb_tbl[0] = '{1'b0, 16'h8000, 16'h0010}; rb_tbl[1] = '{1'b0, 16'h8100, 16'h0111};
    rb_tbl[2] = '{1'b0, 16'h8200, 16'h0212}; rb_tbl[3] = '{1'b0, 16'h8300, 16'h0313};
    rb_tbl[4] = '{1'b0, 16'h8400, 16'h0414};

    cfg_rst_in = 1'b1;
    wr_req = 1'b0; wr_chan = 1'b0; wr_word = '0;
    rd_req = 1'b0; rd_chan = 1'b0; init_req = 1'b0;
    repeat (3) @(posedge cfg_spi_clk);

    // Reset values
    check("rst_eng_start", {31'd0, eng_start}, 32'd0);
    check("rst_eng_chan",  {31'd0, eng_chan},  32'd0);
    check("rst_eng_word",  {16'd0, eng_word},  32'd0);
    check("rst_rd_valid",  {31'd0, rd_valid},  32'd0);
    check("rst_rd_data",   rd_data,            32'd0);
    check("rst_wr_full",   {31'd0, wr_full},   32'd0);
    check("rst_busy",      {31'd0, busy},      32'd0);
    check("rst_init_done", {31'd0, init_done}, 32'd0);
    check("rst_err",       {29'd0, err_flags}, 32'd0);

    // Power-up init sequence
    cfg_rst_in = 1'b0;
    wait_quiet("init");
    check_init_seq("init");
    check("init_done", {31'd0, init_done}, 32'd1);
    check("init_err",  {29'd0, err_flags}, 32'd0);

    // Readback burst on ADC1
    starts.delete(); rds.delete();
    pulse(1'b0, 1'b1, 1'b0, 1'b0, 16'h0, 1'b1);
    wait_quiet("rb1");
    check("rb1_frames", 32'(starts.size()), 32'd5);
    check_rb("rb1", 1'b1, 0);

    // Write and readback requested together: write wins
    starts.delete(); rds.delete();
    pulse(1'b1, 1'b1, 1'b0, 1'b0, 16'h1234, 1'b0);
    check("wr_full_set", {31'd0, wr_full}, 32'd1);
    wait_starts("wrrd", 2);
    check("wr_full_clr", {31'd0, wr_full}, 32'd0);
    wait_quiet("wrrd");
    check("wrrd_frames", 32'(starts.size()), 32'd6);
    if (starts.size() > 0) check("wrrd_wrframe", {15'd0, starts[0]}, {15'd0, 1'b0, 16'h1234});
    check_rb("wrrd", 1'b0, 1);

    // Second write while the first is held is dropped
    starts.delete(); rds.delete();
    pulse(1'b1, 1'b0, 1'b0, 1'b1, 16'h0555, 1'b0);
    pulse(1'b1, 1'b0, 1'b0, 1'b1, 16'h0666, 1'b0);
    wait_quiet("wrdrop");
    check("wrdrop_frames", 32'(starts.size()), 32'd1);
    if (starts.size() > 0) check("wrdrop_frame", {15'd0, starts[0]}, {15'd0, 1'b1, 16'h0555});
    check("wrdrop_err", {29'd0, err_flags}, 32'b001);

    // Engine silent on a write: timeout, then the queued readback runs
    starts.delete(); rds.delete();
    respond = 1'b0;
    pulse(1'b1, 1'b0, 1'b0, 1'b0, 16'h0777, 1'b0);
    wait_starts("tmo", 1);
    respond = 1'b1;
    n = 0;
    while (err_flags[2] !== 1'b1 && n < 400) begin
      @(posedge cfg_spi_clk);
      n++;
      if (n == 3) rd_req = 1'b1;
      else rd_req = 1'b0;
    end
    rd_req = 1'b0;
    check("tmo_cycles", 32'(n), 32'd200);
    check("tmo_busy",   {31'd0, busy},      32'd0);
    check("tmo_wrfull", {31'd0, wr_full},   32'd0);
    check("tmo_err",    {29'd0, err_flags}, 32'b101);
    wait_starts("tmo_rb", 1);
    pulse(1'b0, 1'b1, 1'b0, 1'b0, 16'h0, 1'b1);
    wait_quiet("tmo");
    check("tmo_frames", 32'(starts.size()), 32'd6);
    if (starts.size() > 0) check("tmo_wrframe", {15'd0, starts[0]}, {15'd0, 1'b0, 16'h0777});
    check_rb("tmo", 1'b0, 1);
    check("rddrop_err", {29'd0, err_flags}, 32'b111);

    // Host-requested re-init
    starts.delete(); rds.delete();
    pulse(1'b0, 1'b0, 1'b1, 1'b0, 16'h0, 1'b0);
    check("reinit_done_clr", {31'd0, init_done}, 32'd0);
    wait_quiet("reinit");
    check_init_seq("reinit");
    check("reinit_done", {31'd0, init_done}, 32'd1);

    // Reset during readback word 2
    starts.delete(); rds.delete();
    pulse(1'b0, 1'b1, 1'b0, 1'b0, 16'h0, 1'b0);
    wait_starts("midrst", 3);
    if (starts.size() > 2) check("midrst_word2", {15'd0, starts[2]}, {15'd0, 1'b0, 16'h8200});
    cfg_rst_in = 1'b1;
    #1;
    check("midrst_eng_start", {31'd0, eng_start}, 32'd0);
    check("midrst_eng_word",  {16'd0, eng_word},  32'd0);
    check("midrst_rd_data",   rd_data,            32'd0);
    check("midrst_busy",      {31'd0, busy},      32'd0);
    check("midrst_init_done", {31'd0, init_done}, 32'd0);
    check("midrst_err",       {29'd0, err_flags}, 32'd0);
    repeat (5) @(posedge cfg_spi_clk);
    check("midrst_no_start", 32'(starts.size()), 32'd3);
    starts.delete(); rds.delete();
    cfg_rst_in = 1'b0;
    wait_quiet("postrst");
    check_init_seq("postrst");
    check("postrst_done", {31'd0, init_done}, 32'd1);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/adc_spi_sched.md
ADC_SPI_SCHED -- requirements
Module: adc_spi_sched

Interface
REQ-001 Parameter INIT_WORDS, default 5: power-up register words issued per ADC.
REQ-002 Parameter RD_WORDS, default 5: registers read per readback burst (addresses 0..RD_WORDS-1).
REQ-003 Parameter TMO_CYC, default 200: cycles allowed from eng_start to eng_done.
REQ-004 cfg_spi_clk  in  1  10 MHz config clock; all logic on the falling edge.
REQ-005 cfg_rst_in  in  1  reset, asynchronous, active-high.
REQ-006 wr_req  in  1  one-cycle host write strobe; wr_chan (in, 1) selects ADC; wr_word (in, 16) = {addr8, data8}.
REQ-007 rd_req  in  1  one-cycle readback strobe; rd_chan (in, 1) selects ADC.
REQ-008 init_req  in  1  one-cycle strobe re-running the power-up sequence.
REQ-009 eng_start  out  1  one-cycle launch to the SPI engine; eng_chan (out, 1) selects CS; eng_word (out, 16) frame, bit15 = read flag.
REQ-010 eng_done  in  1  one-cycle engine completion; eng_rdata (in, 8) read byte, valid with eng_done.
REQ-011 rd_valid  out  1  one-cycle; rd_data (out, 32) = {16'h0adc or 16'h1adc per channel, addr8, data8}.
REQ-012 wr_full  out  1  write holding register occupied; init_done  out  1; busy  out  1; err_flags  out  3  sticky {timeout, rd_drop, wr_drop}.

Function
REQ-013 FSM states: IDLE, ARB, LAUNCH, WAIT, NEXT; busy = state != IDLE.
REQ-014 After reset, init pending for both ADCs; init runs ADC0 then ADC1, words {8'h00,8'h80},{8'h01,8'h00},{8'h02,8'h00},{8'h03,8'h00},{8'h04,8'h81}.
REQ-015 wr_req loads a one-deep holding register and sets wr_full next cycle; wr_req while wr_full is dropped and sets err_flags[0].
REQ-016 rd_req sets a one-deep rd pending flag with channel; rd_req while pending or while a burst runs sets err_flags[1], dropped.
REQ-017 ARB priority, fixed: init > write > readback; decided in one cycle; IDLE->ARB when any pending.
REQ-018 Grant is non-preemptive per burst: an init or readback burst completes all words before re-arbitration; a write is a one-word burst.
REQ-019 LAUNCH: eng_start high exactly one cycle with eng_chan/eng_word stable from LAUNCH until eng_done.
REQ-020 Readback word n = {1'b1, 7'(n), 8'h00}; on eng_done, rd_valid next cycle with addr8 = n, data8 = eng_rdata.
REQ-021 WAIT->NEXT on eng_done; NEXT->LAUNCH if words remain, else clears the granted request (wr_full low, rd flag low, init pending bit low) and goes IDLE.
REQ-022 Minimum eng_start spacing: 3 cycles after preceding eng_done.
REQ-023 Timeout: 8-bit counter in WAIT; reaching TMO_CYC sets err_flags[2], aborts the burst, clears its request, goes IDLE; a late eng_done in IDLE is ignored.
REQ-024 init_done rises when both ADC inits complete (or time out); init_req clears init_done and re-queues both ADCs; init_req during an init burst is ignored.
REQ-025 Request arriving the same cycle its slot clears is accepted (clear has priority only over the old entry).
REQ-026 err_flags clear only on reset.

Reset
REQ-027 On cfg_rst_in: state IDLE, eng_start 0, eng_chan 0, eng_word 0, rd_valid 0, rd_data 0, wr_full 0, busy 0, init_done 0, err_flags 0, init pending both ADCs.
REQ-028 Reset mid-burst aborts immediately; no further eng_start until reset deasserts; init restarts at ADC0 word 0.

Structure
REQ-029 Shared package adc_cfg_pkg holds FSM state encoding, init word table, rd_data tags 16'h0adc/16'h1adc.
REQ-030 One sub-module adc_spi_req_slot: one-deep holding register with load/clear/drop flag, instanced for write and readback.

Verification
REQ-031 Reset release, engine answers eng_done 10 cycles after each start -> 10 eng_start, ADC0 words 0080,0100,0200,0300,0481 then ADC1 same, init_done=1.
REQ-032 After init, rd_req chan1, eng_rdata = 8'h10+n -> five rd_valid, rd_data 1adc0010,1adc0111,...,1adc0414.
REQ-033 wr_req and rd_req same cycle while idle -> write word issued first, then 5-word readback; wr_full clears at write completion.
REQ-034 Two wr_req while first pending -> second dropped, err_flags=3'b001, only first word reaches engine.
REQ-035 Engine never returns eng_done -> err_flags[2] set after 200 cycles in WAIT, FSM IDLE, next pending request served.
REQ-036 cfg_rst_in asserted during readback word 2 -> all outputs at reset values within same edge, init resequences from ADC0 word 0.
